// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one partial-product step per clock.
// Optional MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
    parameter int NUM_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_BITS-1:0]     multiplier,
    input  logic [NUM_BITS-1:0]     multiplicand,
    output logic [2*NUM_BITS-1:0]   product
);

    localparam int PW = 2 * NUM_BITS;
    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, next_state;
    logic [NUM_BITS-1:0] a_reg;
    logic [PW-1:0]       b_reg;
    logic [PW-1:0]       acc;
    logic [CW-1:0]       count;
    logic                last_step;

    // One shift-and-add step; full 2N-bit width, so the sum cannot overflow.
    function automatic logic [PW-1:0] add_partial(input logic [PW-1:0] sum,
                                                  input logic [PW-1:0] addend,
                                                  input logic          sel);
        return sel ? (sum + addend) : sum;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        last_step  = (count == CW'(1));
`ifdef MULT_EARLY_TERM_EN
        // Nothing left to add once the bits still to be shifted in are all zero.
        last_step  = last_step || (a_reg[NUM_BITS-1:1] == '0);
`endif
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= multiplier;
                        b_reg <= {{NUM_BITS{1'b0}}, multiplicand};
                        acc   <= '0;
                        count <= CW'(NUM_BITS);
                    end
                end
                CALC: begin
                    acc   <= add_partial(acc, b_reg, a_reg[0]);
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg << 1;
                    count <= count - CW'(1);
                end
                DONE: begin
                    // The only place the visible result moves, so it stays stable during CALC.
                    product <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (NUM_BITS=7): vector table, random
// operands against a plain a*b model, and hand-written reset/restart/hold sequences.
module tb_seq_shift_add_multiplier;

    localparam int N = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    multiplier;
    logic [N-1:0]    multiplicand;
    logic [2*N-1:0]  product;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shift_add_multiplier #(.NUM_BITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
        string          name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: product=%0d required=%0d", name, act, req);
        end
    endtask

    // Edges from the accepting edge until product carries the new result.
    function automatic int exp_lat(input logic [N-1:0] a);
`ifdef MULT_EARLY_TERM_EN
        for (int i = N - 1; i >= 0; i--)
            if (a[i]) return i + 2;
        return 2;
`else
        return N + 1;
`endif
    endfunction

    task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [2*N-1:0] exp, input string name);
        logic [2*N-1:0] prev;
        int lat;
        lat = exp_lat(a);
        @(negedge clk);
        prev         = product;
        start        = 1'b1;
        multiplier   = a;
        multiplicand = b;
        @(negedge clk);
        start        = 1'b0;
        multiplier   = N'($urandom);
        multiplicand = N'($urandom);
        for (int e = 1; e <= lat; e++) begin
            @(negedge clk);
            if (e < lat) check({name, "_hold"}, product, prev);
            else         check(name, product, exp);
        end
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        int lat1, lat2, tot;

        vecs[0] = '{7'd15,  7'd15,  14'd225,   "a15_b15"};
        vecs[1] = '{7'd0,   7'd12,  14'd0,     "a0_b12"};
        vecs[2] = '{7'd1,   7'd2,   14'd2,     "a1_b2"};
        vecs[3] = '{7'd0,   7'd0,   14'd0,     "a0_b0"};
        vecs[4] = '{7'd92,  7'd75,  14'd6900,  "a92_b75"};
        vecs[5] = '{7'd127, 7'd127, 14'd16129, "a127_b127"};
        vecs[6] = '{7'd127, 7'd1,   14'd127,   "a127_b1"};
        vecs[7] = '{7'd1,   7'd127, 14'd127,   "a1_b127"};
        vecs[8] = '{7'd64,  7'd64,  14'd4096,  "a64_b64"};
        vecs[9] = '{7'd100, 7'd3,   14'd300,   "a100_b3"};

        rst = 1'b1; start = 1'b0; multiplier = '0; multiplicand = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_product", product, '0);

        for (int i = 0; i < 10; i++)
            run_mult(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 30; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i == 0) ra = '0;
            if (i == 1) rb = '0;
            run_mult(ra, rb, (2*N)'(int'(ra) * int'(rb)), "random");
        end

        // Pulsing start and changing operands mid-CALC must not disturb the running multiply.
        run_mult(7'd100, 7'd3, 14'd300, "pre_midstart");
        @(negedge clk);
        start = 1'b1; multiplier = 7'd13; multiplicand = 7'd11;
        @(negedge clk);
        start = 1'b0;
        lat1 = exp_lat(7'd13);
        for (int e = 1; e <= lat1; e++) begin
            @(negedge clk);
            if (e == 1) begin start = 1'b1; multiplier = 7'd127; multiplicand = 7'd127; end
            if (e == 3) start = 1'b0;
            if (e < lat1) check("midstart_hold", product, 14'd300);
            else          check("midstart_result", product, 14'd143);
        end
        for (int e = 0; e < N + 3; e++) begin
            @(negedge clk);
            check("midstart_not_queued", product, 14'd143);
        end

        // Start held high: back-to-back multiplies, operands changed right after capture.
        @(negedge clk);
        start = 1'b1; multiplier = 7'd3; multiplicand = 7'd5;
        @(negedge clk);
        multiplier = 7'd7; multiplicand = 7'd9;
        lat1 = exp_lat(7'd3);
        lat2 = exp_lat(7'd7);
        tot  = lat1 + 1 + lat2;
        for (int e = 1; e <= tot; e++) begin
            @(negedge clk);
            if (e < lat1)      check("held_first_hold", product, 14'd143);
            else if (e < tot)  check("held_first_result", product, 14'd15);
            else begin
                check("held_second_result", product, 14'd63);
                start = 1'b0;
            end
        end
        for (int e = 0; e < N + 3; e++) begin
            @(negedge clk);
            check("held_stop", product, 14'd63);
        end

        // Reset three clocks into CALC aborts the multiply and clears the result.
        @(negedge clk);
        start = 1'b1; multiplier = 7'd127; multiplicand = 7'd127;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_hold_before", product, 14'd63);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_product", product, '0);
        for (int e = 0; e < N + 3; e++) begin
            @(negedge clk);
            check("midrst_idle", product, '0);
        end
        run_mult(7'd5, 7'd6, 14'd30, "after_midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
